// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM encoding and default operand widths for the
// sequential arithmetic blocks (divider and multiplier).
// Ports: none (package).
package arith_pkg;
    localparam int ARITH_N_W = 16;
    localparam int ARITH_D_W = 8;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arith_state_e;
endpackage

// File: rtl/sequential_divider.sv
// sequential_divider: unsigned restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        begin a division (sampled only in IDLE)
//   dividend     N_W-bit unsigned dividend, captured on accepted start
//   divisor      D_W-bit unsigned divisor, captured on accepted start
//   busy         high while the division steps run
//   done         one-cycle pulse, results valid in that cycle
//   quotient     registered N_W-bit quotient
//   remainder    registered D_W-bit remainder
//   div_by_zero  registered flag, valid with done
module sequential_divider
    import arith_pkg::*;
#(
    parameter int N_W = ARITH_N_W,
    parameter int D_W = ARITH_D_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_by_zero
);
    localparam int C_W = (N_W > 1) ? $clog2(N_W) : 1;

    arith_state_e   r_state;
    arith_state_e   w_next;
    logic [N_W-1:0] r_dividend;
    logic [N_W-1:0] r_q;
    logic [D_W-1:0] r_divisor;
    logic [D_W-1:0] r_rem;
    logic [C_W-1:0] r_cnt;
    logic           w_accept;
    logic           w_zero;
    logic           w_last;
    logic           w_bit;
    logic           w_ge;
    logic [D_W:0]   w_part;
    logic [D_W:0]   w_diff;
    logic [D_W-1:0] w_rem_next;
    logic [N_W:0]   w_q_shift;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_zero     = (divisor == '0);
    assign w_last     = (r_cnt == '0);
    // The captured dividend is never shifted; the counter selects the next bit.
    assign w_bit      = r_dividend[r_cnt];
    assign w_part     = {r_rem, w_bit};
    assign w_diff     = w_part - {1'b0, r_divisor};
    assign w_ge       = (w_part >= {1'b0, r_divisor});
    // When no subtraction happens the partial value is below the divisor, so its MSB is 0.
    assign w_rem_next = w_ge ? w_diff[D_W-1:0] : w_part[D_W-1:0];
    assign w_q_shift  = {r_q, w_ge};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == ST_IDLE) ? (start ? (w_zero ? ST_DONE : ST_RUN) : ST_IDLE) :
                 (r_state == ST_RUN)  ? (w_last ? ST_DONE : ST_RUN) :
                                        ST_IDLE;
    end

    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_rem      <= '0;
            r_q        <= '0;
            r_cnt      <= C_W'(N_W - 1);
            // A zero divisor skips the steps and publishes the saturated result at once.
            if (w_zero) begin
                quotient    <= '1;
                remainder   <= dividend[D_W-1:0];
                div_by_zero <= 1'b1;
            end
        end else if (r_state == ST_RUN) begin
            r_rem <= w_rem_next;
            r_q   <= w_q_shift[N_W-1:0];
            r_cnt <= r_cnt - C_W'(1);
            if (w_last) begin
                quotient    <= w_q_shift[N_W-1:0];
                remainder   <= w_rem_next;
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: directed and randomized self-checking bench against an arithmetic reference model.
module tb_sequential_divider;
    localparam int N_W = 16;
    localparam int D_W = 8;

    logic           clk;
    logic           reset;
    logic           start;
    logic [N_W-1:0] dividend;
    logic [D_W-1:0] divisor;
    logic           busy;
    logic           done;
    logic [N_W-1:0] quotient;
    logic [D_W-1:0] remainder;
    logic           div_by_zero;

    int checks = 0;
    int errors = 0;
    logic [N_W-1:0] m_q = '0;
    logic [D_W-1:0] m_r = '0;
    logic           m_z = 1'b0;

    sequential_divider #(.N_W(N_W), .D_W(D_W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of the IDLE cycle after DONE.
    task automatic divide(input logic [N_W-1:0] a, input logic [D_W-1:0] b, input string tag);
        int lat;
        int bad_busy;
        int bad_hold;
        int exp_lat;
        logic [N_W-1:0] eq;
        logic [D_W-1:0] er;
        logic           ez;
        if (b == '0) begin
            eq = '1;
            er = a[D_W-1:0];
            ez = 1'b1;
            exp_lat = 1;
        end else begin
            eq = a / N_W'(b);
            er = D_W'(a % N_W'(b));
            ez = 1'b0;
            exp_lat = N_W + 1;
        end
        start = 1'b1;
        dividend = a;
        divisor = b;
        lat = 0;
        bad_busy = 0;
        bad_hold = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) bad_busy++;
            if ({quotient, remainder, div_by_zero} !== {m_q, m_r, m_z}) bad_hold++;
            start = (lat == 5) || ($urandom_range(0, 3) == 0);
            dividend = N_W'($urandom);
            divisor = D_W'($urandom);
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        chk({tag, "_busy_done"}, 32'(busy), 0);
        chk({tag, "_busy_run"}, bad_busy, 0);
        chk({tag, "_hold_run"}, bad_hold, 0);
        m_q = eq;
        m_r = er;
        m_z = ez;
        start = 1'b1;
        dividend = N_W'($urandom);
        divisor = D_W'($urandom);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 0);
        chk({tag, "_busy_idle"}, 32'(busy), 0);
        chk({tag, "_hold_idle"}, 32'({quotient, remainder, div_by_zero}), 32'({m_q, m_r, m_z}));
        start = 1'b0;
    endtask

    initial begin
        logic [N_W-1:0] a;
        logic [D_W-1:0] b;
        int seen;
        reset = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'({busy, done, quotient, remainder, div_by_zero}), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", 32'({busy, done}), 0);

        divide(16'h000F, 8'h05, "r031");
        chk("r031_q_const", 32'(quotient), 32'h0003);
        chk("r031_r_const", 32'(remainder), 32'h00);
        divide(16'd1000, 8'd7, "r032a");
        chk("r032a_q_const", 32'(quotient), 142);
        chk("r032a_r_const", 32'(remainder), 6);
        divide(16'hFFFF, 8'hFF, "r032b");
        chk("r032b_q_const", 32'(quotient), 32'h0101);
        chk("r032b_r_const", 32'(remainder), 32'h00);
        divide(16'h0003, 8'h05, "r033");
        chk("r033_q_const", 32'(quotient), 32'h0000);
        chk("r033_r_const", 32'(remainder), 32'h03);
        divide(16'h1234, 8'h00, "r034");
        chk("r034_q_const", 32'(quotient), 32'hFFFF);
        chk("r034_r_const", 32'(remainder), 32'h34);
        chk("r034_dbz_const", 32'(div_by_zero), 1);
        divide(16'd50000, 8'd201, "r035_first");
        chk("r035_first_q_const", 32'(quotient), 248);
        chk("r035_first_r_const", 32'(remainder), 152);

        start = 1'b1;
        dividend = 16'd5000;
        divisor = 8'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_busy_pre", 32'(busy), 1);
        reset = 1'b0;
        #1;
        chk("abort_rst_outputs", 32'({busy, done, quotient, remainder, div_by_zero}), 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) seen++;
        end
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("abort_no_done", seen, 0);
        m_q = '0;
        m_r = '0;
        m_z = 1'b0;
        divide(16'd100, 8'd9, "r035_new");
        chk("r035_new_q_const", 32'(quotient), 11);
        chk("r035_new_r_const", 32'(remainder), 1);

        for (int i = 0; i < 1000; i++) begin
            a = ($urandom_range(0, 3) == 0) ? N_W'($urandom_range(0, 300)) : N_W'($urandom);
            b = ($urandom_range(0, 15) == 0) ? D_W'(0) : D_W'($urandom);
            divide(a, b, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
